// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer ALU with a valid/ready handshake on
// both sides. Most operations finish in one cycle. Shifts by a non-zero
// amount run through a serial 1-bit-per-cycle shifter, so they take
// shamt+1 cycles.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      synchronous active-low reset
//   valid_i     upstream offers an operation
//   ready_o     unit can accept an operation this cycle (combinational on ready_i)
//   alu_ctrl_i  operation code (0000..1001 legal, 1010..1111 undefined)
//   op_a_i      operand A
//   op_b_i      operand B; bits [4:0] are the shift amount
//   valid_o     result_o / zero_o / illegal_o are valid
//   ready_i     downstream consumes the result
//   result_o    registered ALU result
//   zero_o      registered flag, result_o == 0
//   illegal_o   registered flag, accepted code was undefined
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] shift_reg;
  logic [4:0]      shift_cnt;
  logic [3:0]      shift_ctrl;

  logic            accept;
  logic            start_serial;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shift_next;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == OP_SLL) || (ctrl == OP_SRL) || (ctrl == OP_SRA);
  endfunction

  // Single-cycle result. Shift codes only reach this path with shamt == 0,
  // so they simply pass operand A through; no barrel shifter is built.
  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0]      ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        res;
    a_s = a;
    b_s = b;
    case (ctrl)
      OP_ADD:                res = a + b;
      OP_SUB:                res = a - b;
      OP_SLT:                res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:               res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:                res = a ^ b;
      OP_OR:                 res = a | b;
      OP_AND:                res = a & b;
      OP_SLL, OP_SRL, OP_SRA: res = a;
      default:               res = '0;
    endcase
    return res;
  endfunction

  // One step of the serial shifter. SRA replicates bit XLEN-1, which never
  // changes during an arithmetic shift, so it stays equal to captured op_a[31].
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      ctrl,
                                                 input logic [XLEN-1:0] r);
    logic [XLEN-1:0] res;
    case (ctrl)
      OP_SLL:  res = {r[XLEN-2:0], 1'b0};
      OP_SRL:  res = {1'b0, r[XLEN-1:1]};
      default: res = {r[XLEN-1], r[XLEN-1:1]};
    endcase
    return res;
  endfunction

  always_comb begin
    ready_o      = (state == IDLE) || ((state == DONE) && ready_i);
    valid_o      = (state == DONE);
    accept       = valid_i && ready_o;
    start_serial = is_shift(alu_ctrl_i) && (op_b_i[4:0] != 5'd0);
    alu_res      = alu_eval(alu_ctrl_i, op_a_i, op_b_i);
    shift_next   = shift_step(shift_ctrl, shift_reg);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
      shift_cnt <= 5'd0;
    end else if (accept) begin
      // accept is only possible in IDLE or DONE; in DONE this also retires
      // the current result, giving back-to-back issue.
      if (start_serial) begin
        shift_reg  <= op_a_i;
        shift_cnt  <= op_b_i[4:0];
        shift_ctrl <= alu_ctrl_i;
        state      <= SHIFT;
      end else begin
        result_o  <= alu_res;
        zero_o    <= (alu_res == '0);
        illegal_o <= (alu_ctrl_i > OP_AND);
        state     <= DONE;
      end
    end else begin
      case (state)
        SHIFT: begin
          shift_reg <= shift_next;
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            result_o  <= shift_next;
            zero_o    <= (shift_next == '0);
            illegal_o <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; only 32 is supported.
REQ-002 clk_i  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 valid_i  input  1  upstream offers an operation this cycle.
REQ-005 ready_o  output  1  unit can accept an operation this cycle.
REQ-006 alu_ctrl_i  input  4  operation code from alu_control.
REQ-007 op_a_i  input  XLEN  operand A (rs1 or PC).
REQ-008 op_b_i  input  XLEN  operand B (rs2 or immediate); bits [4:0] are the shift amount.
REQ-009 valid_o  output  1  result_o, zero_o and illegal_o are valid.
REQ-010 ready_i  input  1  downstream consumes the result this cycle.
REQ-011 result_o  output  XLEN  registered ALU result.
REQ-012 zero_o  output  1  registered flag, high when result_o == 0.
REQ-013 illegal_o  output  1  registered flag, high when the accepted alu_ctrl_i was an undefined code.

Function
REQ-014 Operation codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND; codes 1010-1111 are undefined.
REQ-015 ADD and SUB wrap modulo 2^32; no overflow or carry output exists.
REQ-016 SLT compares signed (two's complement); SLTU compares unsigned; each produces 32'd1 or 32'd0.
REQ-017 An undefined code produces result_o = 0, zero_o = 1 and illegal_o = 1, and completes with 1-cycle latency.
REQ-018 States: IDLE, SHIFT, DONE.
REQ-019 ready_o = (state == IDLE) || (state == DONE && ready_i); it is combinational from ready_i.
REQ-020 An operation is accepted at a rising edge where valid_i && ready_o; operands and alu_ctrl_i are captured at that edge.
REQ-021 Non-shift accept, or shift with shamt = 0: the unit goes to DONE; valid_o is high in the next cycle (latency 1).
REQ-022 Shift accept with shamt = s > 0: op_a is loaded into the shift register, a 5-bit counter is loaded with s, and the unit goes to SHIFT.
REQ-023 In SHIFT, each cycle: shift the register by exactly 1 bit and decrement the counter; when the counter reaches 0, go to DONE.
REQ-024 A shift with shamt = s has valid_o high s+1 cycles after accept.
REQ-025 Shift fill: SLL and SRL fill with 0; SRA fills with the captured op_a[31].
REQ-026 In SHIFT, ready_o = 0 and valid_i is ignored.
REQ-027 In DONE, valid_o = 1, and result_o, zero_o and illegal_o hold stable until a rising edge with ready_i = 1.
REQ-028 DONE with ready_i = 1 and no new accept: go to IDLE; valid_o drops the next cycle.
REQ-029 DONE with ready_i = 1 and a simultaneous accept: the result is retired and the new operation is started at the same edge (back-to-back, no bubble for 1-cycle ops).
REQ-030 In IDLE, valid_o = 0; result_o keeps its last value.

Reset
REQ-031 When rst_ni = 0 at a rising edge: state = IDLE, valid_o = 0, result_o = 0, zero_o = 0, illegal_o = 0, shift counter = 0.
REQ-032 Reset asserted in SHIFT or DONE aborts the operation; the aborted result is never presented.
REQ-033 In the first cycle after reset releases, ready_o = 1.

Verification
REQ-034 SUB with A = 0x00000005, B = 0x00000007 -> result_o = 0xFFFFFFFE and zero_o = 0 one cycle after accept; SUB with A = B = 0x1234 -> result_o = 0 and zero_o = 1.
REQ-035 SLT with A = 0xFFFFFFFF, B = 1 -> result_o = 1; SLTU with the same operands -> result_o = 0.
REQ-036 SRA with A = 0x80000000, B = 31 -> ready_o low for 31 cycles, then valid_o high 32 cycles after accept with result_o = 0xFFFFFFFF; SRL with the same operands -> result_o = 0x00000001.
REQ-037 Back-pressure: ADD 3+4 is accepted with ready_i = 0 for 5 cycles -> valid_o stays high and result_o = 7 holds stable for those cycles; on ready_i = 1 with valid_i = 1 carrying XOR, the next result is presented the following cycle.
REQ-038 Reset mid-shift: SLL with shamt = 20 is accepted, and rst_ni = 0 is applied 5 cycles later -> the next cycle shows valid_o = 0, result_o = 0 and ready_o = 1 after release, and no SLL result ever appears.
REQ-039 Undefined code 1100 -> result_o = 0, zero_o = 1 and illegal_o = 1 one cycle after accept; the next legal op clears illegal_o.
